mvau_stream_scheduler: RTL and testbench

MVAU_STREAM_SCHEDULER -- requirements
Module: mvau_stream_scheduler

---
 rtl/mvau_pkg.sv | 11 +
 rtl/mvau_sched_pipe.sv | 30 +++
 rtl/mvau_stream_scheduler.sv | 83 ++++++++
 tb/tb_mvau_stream_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mvau_pkg.sv
// mvau_pkg: shared FSM state type and width helper for the MVAU stream scheduler
package mvau_pkg;

    typedef enum logic [1:0] {IDLE, FILL, REUSE} state_e;

    // Counter width that never collapses to zero bits for a fold count of 1
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mvau_sched_pipe.sv
// mvau_sched_pipe: flag delay line advancing only on en
// Ports: clk, rst (sync, active-high), en (advance), d (flag in), q (oldest flag).
// The consumer's output-valid register is the final stage, so DEPTH-1 flops live here
// and q is the flag that leaves on the next en.
module mvau_sched_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    if (DEPTH == 1) begin : g_pass
        assign q = d;
    end else begin : g_line
        logic [DEPTH-2:0] sr_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else if (en) begin
                sr_q[0] <= d;
                for (int i = 1; i < DEPTH - 1; i++) sr_q[i] <= sr_q[i-1];
            end
        end
        assign q = sr_q[DEPTH-2];
    end

endmodule

// File: rtl/mvau_stream_scheduler.sv
// mvau_stream_scheduler: sequences input-buffer fill/reuse and weight addressing for an MVAU
// Ports: clk, rst (sync, active-high), en (run request), in_v/in_rdy (activation beats),
// out_v/out_rdy (results), ib_wen/ib_ren/ib_addr (input buffer), wgt_addr (weight tile),
// dp_en (datapath advance), acc_clr (accumulator clear, qualified by dp_en).
module mvau_stream_scheduler
    import mvau_pkg::*;
#(
    parameter int SF       = 8,
    parameter int NF       = 2,
    parameter int PIPE_LAT = 3,
    localparam int SF_T    = clog2_min1(SF),
    localparam int NF_T    = clog2_min1(NF),
    localparam int WA_T    = clog2_min1(SF * NF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_v,
    output logic            in_rdy,
    output logic            out_v,
    input  logic            out_rdy,
    output logic            ib_wen,
    output logic            ib_ren,
    output logic [SF_T-1:0] ib_addr,
    output logic [WA_T-1:0] wgt_addr,
    output logic            dp_en,
    output logic            acc_clr
);

    state_e          state_q, state_d;
    logic [SF_T-1:0] sf_q, sf_d;
    logic [NF_T-1:0] nf_q, nf_d;
    logic            out_v_q, out_v_d;
    logic            stall, step, sf_last, nf_last, flag_out;

    always_comb begin
        stall   = out_v_q & ~out_rdy;
        sf_last = sf_q == SF_T'(SF - 1);
        nf_last = nf_q == NF_T'(NF - 1);
        step    = ~rst & ~stall & (((state_q == FILL) & in_v) | (state_q == REUSE));
        sf_d    = ~step ? sf_q : sf_last ? '0 : sf_q + 1'b1;
        nf_d    = ~(step & sf_last) ? nf_q : nf_last ? '0 : nf_q + 1'b1;
        state_d = state_q;
        if (state_q == IDLE)
            state_d = en ? FILL : IDLE;
        else if (step & sf_last)
            state_d = !nf_last ? REUSE : en ? FILL : IDLE;
        // A flag leaving the line on this step keeps out_v high even while a result is accepted
        out_v_d = (step & flag_out) | (out_v_q & ~out_rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sf_q    <= '0;
            nf_q    <= '0;
            out_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sf_q    <= sf_d;
            nf_q    <= nf_d;
            out_v_q <= out_v_d;
        end
    end

    mvau_sched_pipe #(.DEPTH(PIPE_LAT)) u_pipe (
        .clk (clk),
        .rst (rst),
        .en  (step),
        .d   (sf_last),
        .q   (flag_out)
    );

    assign in_rdy   = ~rst & ~stall & (state_q == FILL);
    assign ib_wen   = step & (state_q == FILL);
    assign ib_ren   = step & (state_q == REUSE);
    assign dp_en    = step;
    assign acc_clr  = step & (sf_q == '0);
    assign out_v    = out_v_q;
    assign ib_addr  = sf_q;
    assign wgt_addr = WA_T'(nf_q) * WA_T'(SF) + WA_T'(sf_q);

endmodule

// File: tb/tb_mvau_stream_scheduler.sv
// tb_mvau_stream_scheduler: directed vector bench for an SF=4/NF=2 and an SF=1/NF=1 scheduler
module tb_mvau_stream_scheduler;

    logic clk, rst;
    logic en_a, iv_a, ordy_a, in_rdy_a, ov_a, wen_a, ren_a, dp_a, clr_a;
    logic [1:0] iba_a;
    logic [2:0] wa_a;
    logic en_b, iv_b, ordy_b, in_rdy_b, ov_b, wen_b, ren_b, dp_b, clr_b;
    logic [0:0] iba_b;
    logic [0:0] wa_b;
    logic [8:0] obs_a, obs_b;
    int checks = 0;
    int errors = 0;

    // Expected vector layout: {in_rdy, out_v, ib_wen, ib_ren, wgt_addr[2:0], dp_en, acc_clr}
    typedef struct {
        logic       d;
        logic       en;
        logic       iv;
        logic       ordy;
        logic [8:0] exp;
    } vec_t;
    vec_t vq[$];

    mvau_stream_scheduler #(.SF(4), .NF(2), .PIPE_LAT(3)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .in_v(iv_a), .in_rdy(in_rdy_a),
        .out_v(ov_a), .out_rdy(ordy_a), .ib_wen(wen_a), .ib_ren(ren_a),
        .ib_addr(iba_a), .wgt_addr(wa_a), .dp_en(dp_a), .acc_clr(clr_a)
    );

    mvau_stream_scheduler #(.SF(1), .NF(1), .PIPE_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .in_v(iv_b), .in_rdy(in_rdy_b),
        .out_v(ov_b), .out_rdy(ordy_b), .ib_wen(wen_b), .ib_ren(ren_b),
        .ib_addr(iba_b), .wgt_addr(wa_b), .dp_en(dp_b), .acc_clr(clr_b)
    );

    assign obs_a = {in_rdy_a, ov_a, wen_a, ren_a, wa_a, dp_a, clr_a};
    assign obs_b = {in_rdy_b, ov_b, wen_b, ren_b, 2'b00, wa_b, dp_b, clr_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic d, input logic en, input logic iv, input logic ordy, input logic [8:0] exp);
        vq.push_back('{d, en, iv, ordy, exp});
    endtask

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        logic found;
        // nominal: two full vectors back to back
        add(0, 1, 1, 1, 9'b0_0_0_0_000_0_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(0, 1, 1, 1, 9'b1_0_1_0_001_1_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_010_1_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_011_1_0);
        add(0, 1, 1, 1, 9'b0_0_0_1_100_1_1);
        add(0, 1, 1, 1, 9'b0_0_0_1_101_1_0);
        add(0, 1, 1, 1, 9'b0_1_0_1_110_1_0);
        add(0, 1, 1, 1, 9'b0_0_0_1_111_1_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(0, 1, 1, 1, 9'b1_0_1_0_001_1_0);
        add(0, 1, 1, 1, 9'b1_1_1_0_010_1_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_011_1_0);
        add(0, 1, 1, 1, 9'b0_0_0_1_100_1_1);
        add(0, 1, 1, 1, 9'b0_0_0_1_101_1_0);
        add(0, 1, 1, 1, 9'b0_1_0_1_110_1_0);
        add(0, 1, 1, 1, 9'b0_0_0_1_111_1_0);
        // input gaps during FILL
        add(0, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(0, 1, 0, 1, 9'b1_0_0_0_001_0_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_001_1_0);
        add(0, 1, 0, 1, 9'b1_1_0_0_010_0_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_010_1_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_011_1_0);
        add(0, 1, 1, 1, 9'b0_0_0_1_100_1_1);
        add(0, 1, 1, 1, 9'b0_0_0_1_101_1_0);
        add(0, 1, 1, 1, 9'b0_1_0_1_110_1_0);
        add(0, 1, 1, 1, 9'b0_0_0_1_111_1_0);
        // backpressure for 5 cycles while out_v is high
        add(0, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(0, 1, 1, 1, 9'b1_0_1_0_001_1_0);
        for (int k = 0; k < 5; k++) add(0, 1, 1, 0, 9'b0_1_0_0_010_0_0);
        add(0, 1, 1, 1, 9'b1_1_1_0_010_1_0);
        add(0, 1, 1, 1, 9'b1_0_1_0_011_1_0);
        // en dropped mid-vector: vector completes, then IDLE
        add(0, 1, 1, 1, 9'b0_0_0_1_100_1_1);
        add(0, 0, 1, 1, 9'b0_0_0_1_101_1_0);
        add(0, 0, 1, 1, 9'b0_1_0_1_110_1_0);
        add(0, 0, 1, 1, 9'b0_0_0_1_111_1_0);
        add(0, 0, 1, 1, 9'b0_0_0_0_000_0_0);
        add(0, 0, 1, 1, 9'b0_0_0_0_000_0_0);
        // SF=1, NF=1: every beat clears and yields one result 3 steps later
        add(1, 1, 0, 1, 9'b0_0_0_0_000_0_0);
        add(1, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(1, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(1, 1, 0, 1, 9'b1_0_0_0_000_0_0);
        add(1, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(1, 1, 1, 1, 9'b1_1_1_0_000_1_1);
        add(1, 1, 0, 1, 9'b1_1_0_0_000_0_0);
        add(1, 1, 1, 1, 9'b1_0_1_0_000_1_1);
        add(1, 1, 1, 1, 9'b1_1_1_0_000_1_1);
        add(1, 1, 1, 1, 9'b1_1_1_0_000_1_1);
        add(1, 1, 0, 1, 9'b1_1_0_0_000_0_0);
        add(1, 1, 0, 1, 9'b1_0_0_0_000_0_0);

        rst = 1'b1;
        en_a = 0; iv_a = 0; ordy_a = 1;
        en_b = 0; iv_b = 0; ordy_b = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_a", obs_a, 9'd0);
        chk("reset_b", obs_b, 9'd0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (vq[i].d) begin
                en_a = 0; iv_a = 0; ordy_a = 1;
                en_b = vq[i].en; iv_b = vq[i].iv; ordy_b = vq[i].ordy;
            end else begin
                en_b = 0; iv_b = 0; ordy_b = 1;
                en_a = vq[i].en; iv_a = vq[i].iv; ordy_a = vq[i].ordy;
            end
            #1;
            chk($sformatf("vec%0d", i), vq[i].d ? obs_b : obs_a, vq[i].exp);
        end

        // reset mid-vector at sf=2, nf=1 with a result pending
        en_b = 0; iv_b = 0; ordy_b = 1;
        en_a = 1; iv_a = 1; ordy_a = 1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            #1;
            if (wa_a == 3'd6) found = 1'b1;
        end
        chk("reach_sf2_nf1", {8'b0, found}, 9'd1);
        chk("pending_out_v", {8'b0, ov_a}, 9'd1);
        rst = 1'b1;
        #1;
        chk("rst_comb_outputs", obs_a & 9'b1_0_1_1_000_1_1, 9'd0);
        @(negedge clk);
        #1;
        chk("rst_state", obs_a, 9'd0);
        chk("rst_ib_addr", {7'b0, iba_a}, 9'd0);
        rst = 1'b0;
        #1;
        chk("idle_after_rst", obs_a, 9'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("restart%0d", k), obs_a, {1'b1, 1'b0, 1'b1, 1'b0, 3'(k), 1'b1, k == 0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
